// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: decoupled instruction-fetch front end.
//
// Issues in-order word fetches to an instruction memory with variable latency.
// Each granted request is tagged with its PC in a small in-order tag FIFO. The
// returned instruction is paired with that PC and buffered in a DEPTH-entry
// FIFO that ID drains through a valid/ready handshake. A redirect flushes the
// FIFO in one cycle. Responses to requests that were still in flight at the
// redirect are counted off and dropped as they come back.
//
// Ports:
//   clk            rising-edge clock for all state
//   reset          asynchronous, active-low reset
//   imem_req       fetch request valid
//   imem_addr      fetch address (current fetch_pc)
//   imem_gnt       memory accepts the request this cycle
//   imem_rvalid    response valid (in request order, >= 1 cycle after grant)
//   imem_rdata     returned instruction word
//   redirect_valid taken branch/jump: flush and refetch from redirect_pc
//   redirect_pc    new fetch address
//   inst_valid     FIFO head valid
//   inst           head instruction
//   inst_pc        PC of the head instruction
//   inst_ready     ID consumes the head this cycle
//   count          FIFO occupancy
//   full, empty    count == DEPTH, count == 0
module rv_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   inst_valid,
    output logic [31:0]            inst,
    output logic [XLEN-1:0]        inst_pc,
    input  logic                   inst_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Holds imem_req low until the first clock edge after reset release.
    logic            started_reg;
    logic [XLEN-1:0] fetch_pc_reg;

    // Instruction FIFO
    logic [31:0]     data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;

    // PC tags of granted, still-live requests
    logic [XLEN-1:0] tag_mem  [DEPTH];
    logic [PW-1:0]   tag_rd_ptr_reg;
    logic [PW-1:0]   tag_wr_ptr_reg;

    // outstanding counts every granted request not yet answered, live or
    // stale; discard counts the stale ones still to come back.
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   discard_reg;

    logic [CW:0]      in_use;
    logic             transfer;
    logic             live_rsp;
    logic             drop_rsp;
    logic             push;
    logic             pop;
    logic [CW-1:0]    outstanding_next;
    logic [CW-1:0]    discard_next;
    logic [CW-1:0]    count_next;
    logic [DEPTH-1:0] data_wr_en;
    logic [DEPTH-1:0] tag_wr_en;

    always_comb begin
        // Reserving a FIFO slot for every outstanding request guarantees a
        // live response always finds room.
        in_use     = {1'b0, count_reg} + {1'b0, outstanding_reg};
        imem_req   = started_reg & ~redirect_valid & (in_use < (CW+1)'(DEPTH));
        transfer   = imem_req & imem_gnt;
        inst_valid = (count_reg != '0);
        live_rsp   = imem_rvalid & (discard_reg == '0);
        drop_rsp   = imem_rvalid & (discard_reg != '0);
        push       = live_rsp & ~redirect_valid;
        pop        = inst_valid & inst_ready & ~redirect_valid;

        outstanding_next = outstanding_reg + CW'(transfer) - CW'(imem_rvalid);
        // On redirect every request still unanswered becomes stale, except a
        // response arriving right now, which is dropped in this same cycle.
        if (redirect_valid) begin
            discard_next = outstanding_reg - CW'(imem_rvalid);
        end else begin
            discard_next = discard_reg - CW'(drop_rsp);
        end
        count_next = count_reg + CW'(push) - CW'(pop);
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry_en
            assign data_wr_en[gi] = push & (wr_ptr_reg == PW'(gi));
            assign tag_wr_en[gi]  = transfer & (tag_wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Storage. Entries are cleared on reset so inst/inst_pc read zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
                tag_mem[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (data_wr_en[i]) begin
                    data_mem[i] <= imem_rdata;
                    pc_mem[i]   <= tag_mem[tag_rd_ptr_reg];
                end
                if (tag_wr_en[i]) begin
                    tag_mem[i] <= fetch_pc_reg;
                end
            end
        end
    end

    // Control state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started_reg     <= 1'b0;
            fetch_pc_reg    <= RESET_PC;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            tag_rd_ptr_reg  <= '0;
            tag_wr_ptr_reg  <= '0;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            started_reg     <= 1'b1;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            if (redirect_valid) begin
                fetch_pc_reg   <= redirect_pc;
                rd_ptr_reg     <= '0;
                wr_ptr_reg     <= '0;
                count_reg      <= '0;
                tag_rd_ptr_reg <= '0;
                tag_wr_ptr_reg <= '0;
            end else begin
                if (transfer) begin
                    fetch_pc_reg   <= fetch_pc_reg + XLEN'(4);
                    tag_wr_ptr_reg <= tag_wr_ptr_reg + PW'(1);
                end
                if (live_rsp) begin
                    wr_ptr_reg     <= wr_ptr_reg + PW'(1);
                    tag_rd_ptr_reg <= tag_rd_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
                count_reg <= count_next;
            end
        end
    end

    assign imem_addr = fetch_pc_reg;
    assign inst      = data_mem[rd_ptr_reg];
    assign inst_pc   = pc_mem[rd_ptr_reg];
    assign count     = count_reg;
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Directed bench for rv_fetch_queue (DEPTH=4, RESET_PC=0). A small in-order
// memory model with configurable latency answers grants with addr ^ SIG; a
// running expected PC checks every instruction ID pops.
module tb_rv_fetch_queue;

    localparam logic [31:0] SIG = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    rv_fetch_queue #(
        .XLEN    (32),
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_pop = 0;
    int          max_cnt = 0;
    logic [31:0] exp_pc = 32'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, settle, sample, take edge, update model.
    task automatic tick(input logic gnt, input logic rdy, input logic rdr, input logic [31:0] rpc);
        logic        xfer;
        logic        popped;
        logic [31:0] addr_s;
        pend_t       p;
        @(negedge clk);
        imem_gnt       = gnt;
        inst_ready     = rdy;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ SIG;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        xfer   = imem_req & imem_gnt;
        addr_s = imem_addr;
        popped = inst_valid & inst_ready & ~rdr;
        if (popped) begin
            $display("pop cyc=%0d pc=%h inst=%h", cyc + 1, inst_pc, inst);
            check_val("pop_pc", inst_pc, exp_pc);
            check_val("pop_inst", inst, exp_pc ^ SIG);
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        @(posedge clk);
        cyc++;
        if (imem_rvalid) void'(pend.pop_front());
        if (xfer) begin
            p.addr = addr_s;
            p.due  = cyc + lat;
            pend.push_back(p);
        end
        if (rdr) exp_pc = rpc;
        #1;
        if (int'(count) > max_cnt) max_cnt = int'(count);
    endtask

    // Asserts reset away from any clock edge, checks reset values, then
    // releases it mid-high-phase so the next tick ends on edge 1.
    task automatic do_reset(input string tag);
        #2;
        reset          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        pend.delete();
        #1;
        check_val({tag, "_req"},   32'(imem_req),   32'h0);
        check_val({tag, "_addr"},  imem_addr,       32'h0);
        check_val({tag, "_valid"}, 32'(inst_valid), 32'h0);
        check_val({tag, "_inst"},  inst,            32'h0);
        check_val({tag, "_pc"},    inst_pc,         32'h0);
        check_val({tag, "_count"}, 32'(count),      32'h0);
        check_val({tag, "_empty"}, 32'(empty),      32'h1);
        check_val({tag, "_full"},  32'(full),       32'h0);
        repeat (2) @(posedge clk);
        #2;
        reset   = 1'b1;
        cyc     = 0;
        exp_pc  = 32'h0;
        n_pop   = 0;
        max_cnt = 0;
    endtask

    initial begin
        reset          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;

        // Steady stream, 1-cycle memory
        do_reset("rst0");
        lat = 1;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("first_req",  32'(imem_req), 32'h1);
        check_val("first_addr", imem_addr,     32'h0);
        repeat (19) tick(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("steady_pops",   32'(n_pop),        32'd17);
        check_val("steady_cnt_le2", 32'(max_cnt <= 2), 32'h1);

        // Backpressure: ID stalls 10 cycles, then drains in order
        do_reset("rst_bp");
        lat = 1;
        repeat (10) tick(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("bp_count", 32'(count),      32'd4);
        check_val("bp_full",  32'(full),       32'h1);
        check_val("bp_empty", 32'(empty),      32'h0);
        check_val("bp_req",   32'(imem_req),   32'h0);
        check_val("bp_addr",  imem_addr,       32'd16);
        check_val("bp_head",  inst_pc,         32'h0);
        check_val("bp_inst",  inst,            32'h0 ^ SIG);
        repeat (8) tick(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("bp_pops",  32'(n_pop),      32'd8);

        // Redirect with three requests in flight (4-cycle memory)
        do_reset("rst_rd");
        lat = 4;
        repeat (4) tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h100);
        check_val("rd_count", 32'(count), 32'h0);
        check_val("rd_empty", 32'(empty), 32'h1);
        check_val("rd_addr",  imem_addr,  32'h100);
        max_cnt = 0;
        repeat (4) tick(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("rd_stale_dropped", 32'(max_cnt), 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("rd_valid", 32'(inst_valid), 32'h1);
        check_val("rd_pc",    inst_pc,         32'h100);
        check_val("rd_inst",  inst,            32'h100 ^ SIG);
        repeat (6) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect together with a response and a pop (3-cycle memory)
        do_reset("rst_sim");
        lat = 3;
        repeat (5) tick(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("sim_head_valid", 32'(inst_valid), 32'h1);
        check_val("sim_head_pc",    inst_pc,         32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h200);
        check_val("sim_count", 32'(count),      32'h0);
        check_val("sim_empty", 32'(empty),      32'h1);
        check_val("sim_valid", 32'(inst_valid), 32'h0);
        max_cnt = 0;
        repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("sim_stale_dropped", 32'(max_cnt), 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("sim_new_valid", 32'(inst_valid), 32'h1);
        check_val("sim_new_pc",    inst_pc,         32'h200);
        repeat (5) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Grant stall for 5 cycles
        do_reset("rst_gs");
        lat = 1;
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            check_val("gs_req",  32'(imem_req), 32'h1);
            check_val("gs_addr", imem_addr,     32'h0);
        end
        repeat (6) tick(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("gs_pops", 32'(n_pop), 32'd4);

        // Asynchronous reset mid-stream at count=3
        do_reset("rst_ar");
        lat = 1;
        repeat (5) tick(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("ar_count_pre", 32'(count), 32'd3);
        check_val("ar_addr_pre",  imem_addr,  32'd16);
        do_reset("arst");
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("ar_req",  32'(imem_req), 32'h1);
        check_val("ar_addr", imem_addr,     32'h0);
        repeat (8) tick(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("ar_pops", 32'(n_pop), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
